// File: rtl/muldiv_if.sv
// Request/response bundle between the execute-stage issue logic and the iterative
// RV32M multiply/divide unit.
`timescale 1ns/1ps

interface muldiv_if;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    modport master (
        output start, kill, op, a, b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, kill, op, a, b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// 32 CALC cycles per op, divide-by-zero and signed overflow finish in one cycle.
`timescale 1ns/1ps

module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpRem    = 3'b110;

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] opnd_q, opnd_d;
    logic        neg_q, neg_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] result_q, result_d;

    // Operand decode at accept time
    logic        accept;
    logic        a_signed, b_signed;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic        is_div, is_rem;
    logic        div_zero, div_ovf;
    logic [31:0] special_res;
    logic        neg_start;

    always_comb begin
        accept   = bus.start & ~bus.kill & ((state_q == StIdle) | (state_q == StDone));
        a_signed = (bus.op == OpMulh) | (bus.op == OpMulhsu) |
                   (bus.op == OpDiv)  | (bus.op == OpRem);
        b_signed = (bus.op == OpMulh) | (bus.op == OpDiv) | (bus.op == OpRem);
        sign_a   = a_signed & bus.a[31];
        sign_b   = b_signed & bus.b[31];
        mag_a    = sign_a ? -bus.a : bus.a;
        mag_b    = sign_b ? -bus.b : bus.b;
        is_div   = bus.op[2];
        is_rem   = bus.op[2] & bus.op[1];
        div_zero = is_div & (bus.b == 32'd0);
        div_ovf  = ((bus.op == OpDiv) | (bus.op == OpRem)) &
                   (bus.a == 32'h8000_0000) & (bus.b == 32'hFFFF_FFFF);
        if (div_zero) begin
            special_res = is_rem ? bus.a : 32'hFFFF_FFFF;
        end else begin
            special_res = is_rem ? 32'd0 : 32'h8000_0000;
        end
        // Remainder takes the dividend's sign; everything else the XOR of both
        neg_start = is_rem ? sign_a : (sign_a ^ sign_b);
    end

    // One iteration of either datapath, shared 64-bit working register
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic [63:0] div_next;
    logic [63:0] step_next;

    always_comb begin
        mul_sum = {1'b0, prod_q[63:32]};
        if (prod_q[0]) begin
            mul_sum = {1'b0, prod_q[63:32]} + {1'b0, opnd_q};
        end
        mul_next = {mul_sum, prod_q[31:1]};

        rem_sh   = {prod_q[63:32], prod_q[31]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (rem_diff[32]) begin
            div_next = {rem_sh[31:0], prod_q[30:0], 1'b0};
        end else begin
            div_next = {rem_diff[31:0], prod_q[30:0], 1'b1};
        end

        step_next = op_q[2] ? div_next : mul_next;
    end

    // Sign fix applied to the value produced by the final iteration
    logic [63:0] mul_full;
    logic [31:0] mul_res;
    logic [31:0] div_val;
    logic [31:0] div_res;
    logic [31:0] final_res;

    always_comb begin
        mul_full  = neg_q ? -step_next : step_next;
        mul_res   = (op_q == OpMul) ? mul_full[31:0] : mul_full[63:32];
        div_val   = op_q[1] ? step_next[63:32] : step_next[31:0];
        div_res   = neg_q ? -div_val : div_val;
        final_res = op_q[2] ? div_res : mul_res;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        result_d = result_q;

        case (state_q)
            StCalc: begin
                prod_d = step_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = StDone;
                    result_d = final_res;
                    rd_out_d = rd_q;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            op_d  = bus.op;
            rd_d  = bus.rd_in;
            neg_d = neg_start;
            cnt_d = 5'd0;
            // Multiply iterates over the multiplier bits; divide shifts the dividend out
            if (is_div) begin
                opnd_d = mag_b;
                prod_d = {32'd0, mag_a};
            end else begin
                opnd_d = mag_a;
                prod_d = {32'd0, mag_b};
            end
            if (div_zero | div_ovf) begin
                state_d  = StDone;
                result_d = special_res;
                rd_out_d = bus.rd_in;
            end else begin
                state_d = StCalc;
            end
        end

        if (bus.kill) begin
            state_d  = StIdle;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= 3'd0;
            rd_q     <= 5'd0;
            rd_out_q <= 5'd0;
            cnt_q    <= 5'd0;
            opnd_q   <= 32'd0;
            neg_q    <= 1'b0;
            prod_q   <= 64'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == StCalc);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, fed by the register-file read ports (rs1/rs2 operands) and producing a result plus destination index for the register-file write port. It executes one M-extension operation at a time with a start/busy/done handshake. Normal operations use a radix-2 shift-add or restoring-division datapath over 32 iteration cycles. Divide-by-zero and signed-overflow cases complete early.

## Interface
Parameters: none (XLEN fixed at 32).

Clock and reset: one clock; reset is asynchronous and active-high.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only when accepting (state IDLE or DONE)
- kill  in  1  pipeline flush; aborts any in-flight operation
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  32  rs1 operand
- b  in  32  rs2 operand
- rd_in  in  5  destination register index
- busy  out  1  high while state is CALC
- done  out  1  one-cycle pulse; result and rd_out are valid in that cycle
- result  out  32  operation result; held until the next accepted start
- rd_out  out  5  captured rd_in, intended to drive the register-file write address

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE, with busy=0, done=0, result=0, rd_out=0.
- Accept: start=1 and kill=0 in IDLE or DONE.
  - On accept, latch op, rd_in, operand magnitudes, and sign flags.
  - Clear the 5-bit iteration counter.
- Operand signedness:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats a as signed and b as unsigned.
  - MUL, MULHU, DIVU, and REMU treat both operands as unsigned.
  - Signed operands are converted to magnitude plus a sign flag. The final negate applies when the operand signs differ (for REM, the sign of a).
- Special cases, detected at accept. The next state is DONE (no CALC):
  - DIV/DIVU with b=0: result=0xFFFFFFFF.
  - REM/REMU with b=0: result=a.
  - DIV with a=0x80000000 and b=0xFFFFFFFF: result=0x80000000.
  - REM with a=0x80000000 and b=0xFFFFFFFF: result=0.
- Multiply:
  - 64-bit product register; one conditional add and shift per CALC cycle.
  - MUL returns product[31:0] after sign fix.
  - MULH, MULHSU, and MULHU return product[63:32] after the 64-bit two's-complement sign fix.
- Divide:
  - Restoring algorithm; one quotient bit per CALC cycle using a 33-bit partial-remainder subtract.
  - DIV/DIVU return the quotient; REM/REMU return the remainder, each after sign fix.
- CALC to DONE: when the counter reaches 31. Result and sign fix are registered on that edge.
- DONE: done=1 for exactly one cycle.
  - The next state is IDLE, or a new operation if start is accepted in that cycle (back-to-back).
- kill=1 in any state: next state IDLE with done=0. result and rd_out are unchanged.
  - kill takes priority over start in the same cycle.
- start while in CALC is ignored (no queueing). The operation in flight is unaffected.

## Timing
- Start is accepted at rising edge E0.
  - Normal ops: busy=1 in the 32 cycles after E0 (CALC); done=1 in the 33rd cycle after E0.
  - Special cases: done=1 in the cycle immediately after E0; busy stays 0.
- Throughput: one op per 33 cycles (normal) or one per cycle (special cases), using back-to-back accept in DONE.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-operation: state, busy, done, result, and rd_out clear immediately and asynchronously. No done pulse follows reset release.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3), rd_in=5: busy high for 32 cycles, then done with result=0xFFFFFFEB and rd_out=5 in the 33rd cycle.
- MULHU a=b=0xFFFFFFFF: result=0xFFFFFFFE. MULH with the same operands: result=0x00000000. MULHSU a=0xFFFFFFFF, b=2: result=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2: result=0xFFFFFFFD. REM with the same operands: result=0xFFFFFFFF. DIVU a=100, b=7: result=14. REMU with the same operands: result=2.
- Special cases, each with done one cycle after start and busy never high:
  - DIVU a=0x1234, b=0: result=0xFFFFFFFF.
  - REMU with the same operands: result=0x1234.
  - DIV a=0x80000000, b=0xFFFFFFFF: result=0x80000000.
- start pulsed at CALC cycle 10: ignored, and the original result is produced on time. kill at CALC cycle 10: no done, and the next start runs normally. Back-to-back start in the DONE cycle: the second done arrives 33 cycles later.
- rst asserted at CALC cycle 20: busy, done, result, and rd_out are 0 immediately. After release, no done appears within 40 cycles.
